page_nav_ctrl: RTL

- Upstream control stage for the VGA page multiplexer: converts the raw PS2 key levels (up, left, right, down, space) into registered page-select and display-count outputs.
- Replaces the ad-hoc edge-detect logic in the top level.
- Adds input synchronisation, fixed key priority, saturating count, left/right auto-repeat, and one-cycle event pulses for the page renderers and game logic.

---
 rtl/page_nav_ctrl_pkg.sv | 24 ++
 rtl/page_nav_ctrl_key_sync_edge.sv | 34 +++
 rtl/page_nav_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/page_nav_ctrl_pkg.sv
// Shared page and key encodings for the PS2-driven page navigation path.
// The top-level pixel mux and page renderers decode pages with the same constants.
package page_nav_ctrl_pkg;

    typedef enum logic [1:0] {
        PAGE_MAIN   = 2'd0,
        PAGE_HELP   = 2'd1,
        PAGE_CONFIG = 2'd2,
        PAGE_GAME   = 2'd3
    } page_t;

    localparam int NUM_KEYS  = 5;
    localparam int KEY_UP    = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_SPACE = 4;

    // Lowest set bit wins, so a lower key index means a higher priority.
    function automatic logic [NUM_KEYS-1:0] prio_pick(input logic [NUM_KEYS-1:0] ev);
        return ev & (~ev + NUM_KEYS'(1));
    endfunction

endpackage

// File: rtl/page_nav_ctrl_key_sync_edge.sv
// Two-flop key synchroniser plus sample register; produces rising edges per sample
// and the synchronised left/right levels needed for auto-repeat.
module key_sync_edge
    import page_nav_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] rise,
    output logic [1:0]          held_lr
);

    logic [NUM_KEYS-1:0] sync_s1;
    logic [NUM_KEYS-1:0] ks;
    logic [NUM_KEYS-1:0] kp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_s1 <= '0;
            ks      <= '0;
            kp      <= '0;
        end else begin
            sync_s1 <= keys;
            ks      <= sync_s1;
            if (sample_en)
                kp <= ks;
        end
    end

    assign rise    = ks & ~kp;
    assign held_lr = {ks[KEY_RIGHT], ks[KEY_LEFT]};

endmodule

// File: rtl/page_nav_ctrl.sv
// Page-select FSM, saturating display count and left/right auto-repeat driven by
// sampled PS2 key edges; all outputs are registered.
module page_nav_ctrl
    import page_nav_ctrl_pkg::*;
#(
    parameter int NUM_MIN      = 2,
    parameter int NUM_MAX      = 5,
    parameter int NUM_INIT     = 2,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [4:0] keys,
    output logic [1:0] page,
    output logic [2:0] disp_num,
    output logic       page_changed,
    output logic       num_changed,
    output logic       game_start
);

    logic [NUM_KEYS-1:0] rise;
    logic [1:0]          held_lr;

    key_sync_edge u_key_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .keys      (keys),
        .rise      (rise),
        .held_lr   (held_lr)
    );

    page_t             page_q, page_nxt;
    logic [2:0]        num_q, num_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt, cnt_inc;
    logic              armed_q, armed_nxt;
    logic              start_nxt;
    logic              single_l, single_r, rep_ok, rep_fire;
    logic [NUM_KEYS-1:0] rep_vec, ev, act;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page_q       <= PAGE_MAIN;
            num_q        <= 3'(NUM_INIT);
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            page_changed <= 1'b0;
            num_changed  <= 1'b0;
            game_start   <= 1'b0;
        end else begin
            page_q       <= page_nxt;
            num_q        <= num_nxt;
            cnt_q        <= cnt_nxt;
            armed_q      <= armed_nxt;
            page_changed <= (page_nxt != page_q);
            num_changed  <= (num_nxt != num_q);
            game_start   <= start_nxt;
        end
    end

    always_comb begin
        single_l  = held_lr[0] & ~held_lr[1];
        single_r  = held_lr[1] & ~held_lr[0];
        // A fresh left/right press restarts the hold; an up edge cancels it.
        rep_ok    = (page_q == PAGE_CONFIG) && (single_l || single_r) &&
                    !rise[KEY_UP] && !rise[KEY_LEFT] && !rise[KEY_RIGHT];
        cnt_inc   = cnt_q + CNT_W'(1);
        rep_fire  = rep_ok && (cnt_inc == (armed_q ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY)));
        rep_vec   = '0;
        rep_vec[single_l ? KEY_LEFT : KEY_RIGHT] = rep_fire;
        ev        = rise | rep_vec;
        act       = sample_en ? prio_pick(ev) : '0;

        page_nxt  = page_q;
        num_nxt   = num_q;
        start_nxt = 1'b0;
        case (page_q)
            PAGE_MAIN: begin
                if (act[KEY_UP])
                    page_nxt = PAGE_CONFIG;
                else if (act[KEY_DOWN])
                    page_nxt = PAGE_HELP;
            end
            PAGE_HELP: begin
                if (act[KEY_DOWN])
                    page_nxt = PAGE_MAIN;
            end
            PAGE_CONFIG: begin
                if (act[KEY_DOWN]) begin
                    page_nxt = PAGE_MAIN;
                end else if (act[KEY_SPACE]) begin
                    page_nxt  = PAGE_GAME;
                    start_nxt = 1'b1;
                end else if (act[KEY_LEFT] && (num_q > 3'(NUM_MIN))) begin
                    num_nxt = num_q - 3'd1;
                end else if (act[KEY_RIGHT] && (num_q < 3'(NUM_MAX))) begin
                    num_nxt = num_q + 3'd1;
                end
            end
            PAGE_GAME: begin
                if (act[KEY_DOWN])
                    page_nxt = PAGE_MAIN;
            end
            default: page_nxt = PAGE_MAIN;
        endcase

        cnt_nxt   = cnt_q;
        armed_nxt = armed_q;
        if (sample_en) begin
            if (rep_ok && (page_nxt == PAGE_CONFIG)) begin
                cnt_nxt   = rep_fire ? '0 : cnt_inc;
                armed_nxt = armed_q | rep_fire;
            end else begin
                cnt_nxt   = '0;
                armed_nxt = 1'b0;
            end
        end
    end

    assign page     = page_q;
    assign disp_num = num_q;

endmodule
